// File: rtl/sdram_wr_arbiter.sv
// rtl/sdram_wr_arbiter.sv - two-requester frame-granular arbiter feeding the SDRAM write FIFO
//
// Purpose: grants one requester a whole frame of FRAME_LEN words at a time,
// forwards its words into the SDRAM write FIFO with one cycle of latency and
// alternates ownership round-robin when both requesters are waiting.
//
// Ports:
//   clk_50m         - system clock, all logic on the rising edge
//   rst             - asynchronous active-high reset
//   sdram_init_done - SDRAM controller ready; low blocks grants and aborts a frame
//   fifo_full       - write-FIFO almost-full backpressure, stalls transfers
//   req0/req1       - frame-write request levels (0: pattern gen, 1: resize engine)
//   valid0/valid1   - data word valid from each requester
//   data0/data1     - data word from each requester
//   ready0/ready1   - word accepted this cycle when the matching valid is high
//   wr_en/wr_data   - registered FIFO write strobe and data
//   grant           - one-hot owner of the current frame, 00 when idle
//   frame_done      - one-cycle pulse after the last word of a frame
//   frame_abort     - one-cycle pulse when a frame is cut short by sdram_init_done
module sdram_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int FRAME_LEN  = 384000
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  sdram_init_done,
  input  logic                  fifo_full,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  valid0,
  input  logic                  valid1,
  input  logic [FIFO_WIDTH-1:0] data0,
  input  logic [FIFO_WIDTH-1:0] data1,
  output logic                  ready0,
  output logic                  ready1,
  output logic                  wr_en,
  output logic [FIFO_WIDTH-1:0] wr_data,
  output logic [1:0]            grant,
  output logic                  frame_done,
  output logic                  frame_abort
);

  localparam logic [31:0] FRAME_LEN_W = 32'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  grant_nxt;
  logic [31:0] beat_cnt;
  logic [31:0] beat_cnt_nxt;
  logic        rr_ptr;          // 0: requester 0 wins a tie, 1: requester 1 wins
  logic        rr_ptr_nxt;
  logic        frame_done_nxt;
  logic        frame_abort_nxt;
  logic        can_take;
  logic        beat;

  // The count guard keeps a frame from ever accepting more than FRAME_LEN words.
  assign can_take = (state == XFER) && !fifo_full && (beat_cnt < FRAME_LEN_W);
  assign ready0   = can_take & grant[0];
  assign ready1   = can_take & grant[1];
  assign beat     = (valid0 & ready0) | (valid1 & ready1);

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    beat_cnt_nxt    = beat_cnt;
    rr_ptr_nxt      = rr_ptr;
    frame_done_nxt  = 1'b0;
    frame_abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sdram_init_done && (req0 || req1)) begin
          state_nxt    = XFER;
          beat_cnt_nxt = '0;
          if (req0 && req1) begin
            grant_nxt = rr_ptr ? 2'b10 : 2'b01;
          end else begin
            grant_nxt = req1 ? 2'b10 : 2'b01;
          end
        end
      end
      XFER: begin
        // Losing the controller outranks everything, including a final beat.
        if (!sdram_init_done) begin
          state_nxt       = IDLE;
          grant_nxt       = '0;
          beat_cnt_nxt    = '0;
          frame_abort_nxt = 1'b1;
        end else if (beat) begin
          beat_cnt_nxt = beat_cnt + 32'd1;
          if (beat_cnt == FRAME_LEN_W - 32'd1) begin
            state_nxt      = DONE;
            frame_done_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        // Point at whoever did not own this frame.
        state_nxt  = IDLE;
        grant_nxt  = '0;
        rr_ptr_nxt = grant[0];
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      beat_cnt    <= '0;
      rr_ptr      <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      beat_cnt    <= beat_cnt_nxt;
      rr_ptr      <= rr_ptr_nxt;
      frame_done  <= frame_done_nxt;
      frame_abort <= frame_abort_nxt;
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en   <= beat;
      wr_data <= beat ? (grant[1] ? data1 : data0) : '0;
    end
  end

endmodule
